// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the 3x4 keypad scanner: key codes, scan state
// encoding and the row/column to frame-bit mapping.
package keypad_scanner_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;
  localparam int NUM_KEYS = 12;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;
  localparam logic [3:0] KEY_NONE = 4'd15;

  // Enum value doubles as the column index being driven.
  typedef enum logic [1:0] {
    SCAN_COL0 = 2'd0,
    SCAN_COL1 = 2'd1,
    SCAN_COL2 = 2'd2
  } scan_state_t;

  // Frame bit index of a key: row*3 + col.
  function automatic logic [3:0] key_bit(input logic [1:0] row, input logic [1:0] col);
    return ({2'b00, row} * 4'd3) + {2'b00, col};
  endfunction

  // Key code of a frame bit. Layout: row0 1 2 3, row1 4 5 6, row2 7 8 9, row3 * 0 #.
  function automatic logic [3:0] bit_to_code(input int idx);
    logic [3:0] code;
    case (idx)
      0:  code = 4'd1;
      1:  code = 4'd2;
      2:  code = 4'd3;
      3:  code = 4'd4;
      4:  code = 4'd5;
      5:  code = 4'd6;
      6:  code = 4'd7;
      7:  code = 4'd8;
      8:  code = 4'd9;
      9:  code = KEY_STAR;
      10: code = 4'd0;
      11: code = KEY_HASH;
      default: code = KEY_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_key_decode.sv
// Combinational decode of a debounced 12-bit key frame into the one-hot
// digit bus, '*'/'#' levels, the binary key code and the multi-key flag.
module key_decode
  import keypad_scanner_pkg::*;
(
  input  logic [11:0] i_frame,
  output logic [9:0]  o_keypad,
  output logic        o_key_star,
  output logic        o_key_hash,
  output logic [3:0]  o_key_code,
  output logic        o_multi_key
);

  logic [3:0] w_count;
  logic [3:0] w_code;

  // Count pressed keys, remember the code of the last one seen, then
  // drive outputs only for the exactly-one-key case.
  always_comb begin
    w_count     = '0;
    w_code      = KEY_NONE;
    o_keypad    = '0;
    o_key_star  = 1'b0;
    o_key_hash  = 1'b0;
    o_key_code  = KEY_NONE;
    o_multi_key = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (i_frame[i]) begin
        w_count = w_count + 4'd1;
        w_code  = bit_to_code(i);
      end
    end
    if (w_count == 4'd1) begin
      o_key_code = w_code;
      if (w_code == KEY_STAR) begin
        o_key_star = 1'b1;
      end else if (w_code == KEY_HASH) begin
        o_key_hash = 1'b1;
      end else begin
        o_keypad = 10'b00_0000_0001 << w_code;
      end
    end else if (w_count > 4'd1) begin
      o_multi_key = 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 3x4 matrix keypad scanner: drives one column at a time, samples the rows
// on the last dwell cycle of each column, debounces whole frames and
// registers the decoded key outputs.
//
// Handshake: o_key_valid is a single-cycle strobe with no ready; it is
// asserted the same cycle the registered outputs first show a newly accepted
// single key, and the consumer must capture it in that cycle.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int COL_DWELL      = 2,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  i_row,
  output logic [2:0]  o_col,
  output logic [9:0]  o_keypad,
  output logic        o_key_star,
  output logic        o_key_hash,
  output logic [3:0]  o_key_code,
  output logic        o_key_valid,
  output logic        o_multi_key,
  output scan_state_t o_dbg_state
);

  localparam int DW = $clog2(COL_DWELL);
  localparam int SW = $clog2(DEBOUNCE_SCANS);
  localparam logic [DW-1:0] DWELL_LAST = DW'(COL_DWELL - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS - 1);

  scan_state_t r_state;
  scan_state_t w_state_next;
  logic [DW-1:0] r_dwell;
  logic          w_last_dwell;
  logic          w_frame_end;
  logic [2:0]    w_col;
  logic [1:0]    w_col_idx;

  logic [11:0]   r_raw;
  logic [11:0]   r_prev;
  logic [11:0]   r_deb;
  logic [11:0]   r_out_frame;
  logic [11:0]   w_frame;
  logic [SW-1:0] r_stable;
  logic [SW-1:0] w_stable_next;

  logic [9:0]    w_keypad;
  logic          w_key_star;
  logic          w_key_hash;
  logic [3:0]    w_key_code;
  logic          w_multi_key;

  logic [9:0]    r_keypad;
  logic          r_key_star;
  logic          r_key_hash;
  logic [3:0]    r_key_code;
  logic          r_key_valid;
  logic          r_multi_key;

  // Scan state register and per-column dwell counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SCAN_COL0;
      r_dwell <= '0;
    end else begin
      r_state <= w_state_next;
      r_dwell <= w_last_dwell ? '0 : (r_dwell + DW'(1));
    end
  end

  // Next scan state and column drive; advance only after the full dwell.
  always_comb begin
    w_state_next = r_state;
    w_col        = 3'b001;
    w_col_idx    = 2'd0;
    w_last_dwell = (r_dwell == DWELL_LAST);
    case (r_state)
      SCAN_COL0: begin
        w_col     = 3'b001;
        w_col_idx = 2'd0;
        if (w_last_dwell) w_state_next = SCAN_COL1;
      end
      SCAN_COL1: begin
        w_col     = 3'b010;
        w_col_idx = 2'd1;
        if (w_last_dwell) w_state_next = SCAN_COL2;
      end
      SCAN_COL2: begin
        w_col     = 3'b100;
        w_col_idx = 2'd2;
        if (w_last_dwell) w_state_next = SCAN_COL0;
      end
      default: begin
        w_state_next = SCAN_COL0;
      end
    endcase
    w_frame_end = w_last_dwell && (r_state == SCAN_COL2);
  end

  // Raw frame with the current column's row bits merged in; only committed
  // on the last dwell cycle so the rows have had time to settle.
  always_comb begin
    w_frame = r_raw;
    for (int r = 0; r < NUM_ROWS; r++) begin
      w_frame[key_bit(2'(r), w_col_idx)] = i_row[r];
    end
  end

  // Stable counter: counts repeats of the same frame, saturating.
  always_comb begin
    w_stable_next = '0;
    if (w_frame == r_prev) begin
      w_stable_next = (r_stable == STABLE_MAX) ? r_stable : (r_stable + SW'(1));
    end
  end

  // Frame capture and debounce: debounced state loads after enough identical frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_raw    <= '0;
      r_prev   <= '0;
      r_stable <= '0;
      r_deb    <= '0;
    end else begin
      if (w_last_dwell) r_raw <= w_frame;
      if (w_frame_end) begin
        r_prev   <= w_frame;
        r_stable <= w_stable_next;
        if (w_stable_next == STABLE_MAX) r_deb <= w_frame;
      end
    end
  end

  key_decode u_key_decode (
    .i_frame     (r_deb),
    .o_keypad    (w_keypad),
    .o_key_star  (w_key_star),
    .o_key_hash  (w_key_hash),
    .o_key_code  (w_key_code),
    .o_multi_key (w_multi_key)
  );

  // Registered outputs; the valid strobe fires when the debounced frame
  // changes to a new single-key value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_frame <= '0;
      r_keypad    <= '0;
      r_key_star  <= 1'b0;
      r_key_hash  <= 1'b0;
      r_key_code  <= KEY_NONE;
      r_key_valid <= 1'b0;
      r_multi_key <= 1'b0;
    end else begin
      r_out_frame <= r_deb;
      r_keypad    <= w_keypad;
      r_key_star  <= w_key_star;
      r_key_hash  <= w_key_hash;
      r_key_code  <= w_key_code;
      r_key_valid <= (r_deb != r_out_frame) && (w_key_code != KEY_NONE);
      r_multi_key <= w_multi_key;
    end
  end

  assign o_col       = w_col;
  assign o_keypad    = r_keypad;
  assign o_key_star  = r_key_star;
  assign o_key_hash  = r_key_hash;
  assign o_key_code  = r_key_code;
  assign o_key_valid = r_key_valid;
  assign o_multi_key = r_multi_key;
  assign o_dbg_state = r_state;

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter COL_DWELL, default 2, clock cycles each column is driven per scan step (minimum 2).
REQ-002 Parameter DEBOUNCE_SCANS, default 4, consecutive identical scan frames required to accept a new key state (minimum 2).
REQ-003 clk  input  1  system clock (1 kHz in the alarm-clock system).
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 col  output  3  column drive, active-high, one-hot; col[0] is the left column.
REQ-006 row  input  4  row sense, active-high, externally pulled low; row[0] is the top row.
REQ-007 keypad  output  10  debounced digit, one-hot, bit n = digit n, level held while the key is held; drives the alarm/clock setting logic directly.
REQ-008 key_star  output  1  debounced '*' held, level.
REQ-009 key_hash  output  1  debounced '#' held, level.
REQ-010 key_code  output  4  binary code of the accepted key: 0-9 digits, 10 '*', 11 '#', 15 none or invalid.
REQ-011 key_valid  output  1  one-cycle pulse when a new single key is accepted.
REQ-012 multi_key  output  1  level, high while the debounced state has more than one key pressed.

Function
REQ-013 Matrix map SHALL be row0: 1 2 3; row1: 4 5 6; row2: 7 8 9; row3: * 0 #, listed as col0 col1 col2.
REQ-014 Scan FSM SHALL have states COL0 -> COL1 -> COL2 -> COL0; each state lasts exactly COL_DWELL cycles, counted by a dwell counter.
REQ-015 col SHALL equal 3'b001, 3'b010, or 3'b100 in COL0, COL1, or COL2 respectively; it is never zero and never multi-hot outside reset.
REQ-016 row SHALL be sampled only on the last dwell cycle of each column, which allows settling; samples are stored into a 12-bit raw frame, bit = row*3 + col.
REQ-017 A frame SHALL complete on the last dwell cycle of COL2; frame period = 3*COL_DWELL cycles.
REQ-018 At frame end: if raw frame equals previous frame, the stable counter increments, saturating at DEBOUNCE_SCANS-1; otherwise it clears to 0. The previous frame then takes the raw frame value.
REQ-019 Debounced state SHALL load the raw frame when the stable counter reaches DEBOUNCE_SCANS-1, which is DEBOUNCE_SCANS identical frames; a bounce of shorter duration never changes outputs.
REQ-020 Outputs SHALL be registered and decoded from the debounced state, updating the cycle after it loads.
- Exactly one key: keypad, key_star, and key_hash reflect that key; key_code set; multi_key=0.
- No key: keypad=0, key_star=0, key_hash=0, key_code=15, multi_key=0.
- More than one key: keypad=0, key_star=0, key_hash=0, key_code=15, multi_key=1.
REQ-021 key_valid SHALL pulse for exactly one cycle, coincident with the output update, when the debounced state changes to a single-key value different from its prior value; release, multi-key, and no-change produce no pulse.
REQ-022 Going multi -> single (e.g. one of two keys released) SHALL produce a key_valid pulse for the remaining key.
REQ-023 Holding a key SHALL produce exactly one key_valid; there is no auto-repeat.
REQ-024 Simultaneous press and release within one frame is treated as the frame pattern; only the debounced frame value matters.

Reset
REQ-025 On rst high, asynchronously: FSM=COL0, col=3'b001, dwell counter=0, raw/previous/debounced frames=0, stable counter=0.
REQ-026 On rst high, outputs SHALL be keypad=0, key_star=0, key_hash=0, key_code=15, key_valid=0, multi_key=0.
REQ-027 Reset asserted mid-scan or mid-debounce SHALL discard the partial frame; after release, the first frame starts at COL0 and full debounce is required again.

Structure
REQ-028 A shared package SHALL hold the key code constants (KEY_STAR=10, KEY_HASH=11, KEY_NONE=15), the scan state encoding, and the 12-bit bit-index mapping.
REQ-029 One sub-module SHALL be used: key_decode, combinational, mapping the 12-bit debounced frame to keypad, key_star, key_hash, key_code, and multi_key; the scanner registers its outputs.

Verification (COL_DWELL=2, DEBOUNCE_SCANS=4, frame=6 cycles; the bench models the matrix so row reflects pressed keys in the driven column)
REQ-030 Press '5' (row1/col1), hold 60 cycles -> keypad=10'b0000100000, key_code=5, exactly one key_valid pulse, no output change before 4 identical frames.
REQ-031 Press '7' for 2 frames, release, repeat 3 times -> keypad stays 0, no key_valid.
REQ-032 Hold '1' and '9' together -> multi_key=1, keypad=0, key_code=15, no key_valid; release '9' -> after debounce keypad=10'b0000000010, one key_valid.
REQ-033 Press '#' then release -> key_hash=1, key_code=11, one pulse; after release and debounce all outputs idle, no pulse.
REQ-034 Assert rst during COL1 of frame 3 of a '0' press -> all outputs at reset values immediately, col=3'b001; '0' accepted only after 4 fresh frames.
REQ-035 Free-running check -> col cycles 001,010,100 with 2-cycle dwell, always one-hot.
